// File: rtl/score_event_sched.sv
// Schedules snake-game score events: queues good (apple) hits, gives wall/self hits priority,
// and spaces issued pulses to the score tracker by at least MIN_GAP low cycles.
module score_event_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     apple_req,
  input  logic                     wall_req,
  input  logic                     self_req,
  output logic                     goodCollButton,
  output logic                     badCollButton,
  output logic [1:0]               game_state,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (MIN_GAP == 0) ? 1 : $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPlay  = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e        state_q;
  logic          armed_q;
  logic          start_q;
  logic          pause_q;
  logic          bad_pending_q;
  logic [GW-1:0] gap_q;
  logic [CW-1:0] count_q;

  logic start_rise;
  logic pause_rise;
  logic in_play;
  logic bad_req;
  logic full;
  logic gap_zero;
  logic issue_bad;
  logic issue_good;
  logic accept_bad;
  logic wr_good;
  logic wr_ok;
  logic drop;

  // armed_q masks the first cycle after reset so a button already held does not count as a rise.
  assign start_rise = armed_q & start & ~start_q;
  assign pause_rise = armed_q & pause & ~pause_q;

  assign in_play  = (state_q == StPlay);
  assign bad_req  = wall_req | self_req;
  assign full     = (count_q == CW'(DEPTH));
  assign gap_zero = (gap_q == '0);

  // The FIFO holds identical tokens, so only its occupancy needs storing.
  assign issue_bad  = in_play & bad_pending_q & gap_zero & ~badCollButton;
  assign issue_good = in_play & ~bad_pending_q & ~bad_req & ~badCollButton &
                      (count_q != '0) & gap_zero;
  assign accept_bad = in_play & bad_req & ~badCollButton;
  assign wr_good    = in_play & apple_req & ~bad_req & ~bad_pending_q & ~badCollButton;
  assign wr_ok      = wr_good & (~full | issue_good);
  assign drop       = wr_good & full & ~issue_good;

  assign game_state = state_q;
  assign pending    = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      armed_q        <= 1'b0;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
      bad_pending_q  <= 1'b0;
      gap_q          <= '0;
      count_q        <= '0;
      overflow       <= 1'b0;
      goodCollButton <= 1'b0;
      badCollButton  <= 1'b0;
    end else begin
      armed_q        <= 1'b1;
      start_q        <= start;
      pause_q        <= pause;
      goodCollButton <= issue_good;
      badCollButton  <= issue_bad;

      unique case (state_q)
        StIdle: begin
          if (start_rise) begin
            state_q       <= StPlay;
            count_q       <= '0;
            bad_pending_q <= 1'b0;
            overflow      <= 1'b0;
            gap_q         <= '0;
          end
        end
        StPlay: begin
          if (badCollButton) begin
            state_q <= StOver;
          end else if (pause_rise) begin
            state_q <= StPause;
          end

          if (issue_bad) begin
            count_q       <= '0;
            bad_pending_q <= 1'b0;
            gap_q         <= GW'(MIN_GAP);
          end else begin
            if (accept_bad) begin
              bad_pending_q <= 1'b1;
            end
            count_q <= count_q + CW'(wr_ok) - CW'(issue_good);
            if (issue_good) begin
              gap_q <= GW'(MIN_GAP);
            end else if (!gap_zero) begin
              gap_q <= gap_q - GW'(1);
            end
          end

          if (drop) begin
            overflow <= 1'b1;
          end
        end
        StPause: begin
          if (pause_rise) begin
            state_q <= StPlay;
          end
        end
        StOver: begin
          if (start_rise) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_score_event_sched.sv
// Directed bench for score_event_sched: a vector table for the main play sequence plus
// hand-written pause and mid-queue reset sequences.
module tb_score_event_sched;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       apple_req = 1'b0;
  logic       wall_req = 1'b0;
  logic       self_req = 1'b0;
  logic       goodCollButton;
  logic       badCollButton;
  logic [1:0] game_state;
  logic [2:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  score_event_sched #(
    .DEPTH  (4),
    .MIN_GAP(2)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .apple_req     (apple_req),
    .wall_req      (wall_req),
    .self_req      (self_req),
    .goodCollButton(goodCollButton),
    .badCollButton (badCollButton),
    .game_state    (game_state),
    .pending       (pending),
    .overflow      (overflow)
  );

  initial forever #5 tb_clk = ~tb_clk;

  typedef struct {
    logic st, pa, ap, wa, se;
    logic eg, eb;
    int   es, ep;
    logic eo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, pa, ap, wa, se, input logic eg, eb, input int es, ep,
                     input logic eo);
    vec_t v;
    v.st = st; v.pa = pa; v.ap = ap; v.wa = wa; v.se = se;
    v.eg = eg; v.eb = eb; v.es = es; v.ep = ep; v.eo = eo;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int eg, eb, es, ep, eo);
    chk({nm, ".good"}, int'(goodCollButton), eg);
    chk({nm, ".bad"}, int'(badCollButton), eb);
    chk({nm, ".state"}, int'(game_state), es);
    chk({nm, ".pending"}, int'(pending), ep);
    chk({nm, ".overflow"}, int'(overflow), eo);
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic drive(input logic st, pa, ap, wa, se);
    start = st; pause = pa; apple_req = ap; wall_req = wa; self_req = se;
  endtask

  int goods;
  int bads;

  initial begin
    // start, pause, apple, wall, self | good, bad, state, pending, overflow (after the edge)
    add(1,0,0,0,0, 0,0,1,0,0);  // IDLE->PLAY
    add(0,0,1,0,0, 0,0,1,1,0);  // three back-to-back apples
    add(0,0,1,0,0, 1,0,1,1,0);
    add(0,0,1,0,0, 0,0,1,2,0);
    add(0,0,0,0,0, 0,0,1,2,0);
    add(0,0,0,0,0, 1,0,1,1,0);
    add(0,0,0,0,0, 0,0,1,1,0);
    add(0,0,0,0,0, 0,0,1,1,0);
    add(0,0,0,0,0, 1,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,0,0);
    add(0,0,1,0,0, 0,0,1,1,0);  // queue two, then apple+wall together
    add(0,0,1,0,0, 1,0,1,1,0);
    add(0,0,1,0,0, 0,0,1,2,0);
    add(0,0,1,1,0, 0,0,1,2,0);
    add(0,0,0,0,0, 0,1,1,0,0);
    add(0,0,0,0,0, 0,0,3,0,0);
    add(0,0,0,0,0, 0,0,3,0,0);
    add(0,1,0,0,0, 0,0,3,0,0);  // pause ignored in OVER
    add(1,0,0,0,0, 0,0,0,0,0);  // OVER->IDLE
    add(0,0,1,0,0, 0,0,0,0,0);  // apple ignored in IDLE
    add(1,0,0,0,0, 0,0,1,0,0);
    for (int i = 0; i < 8; i++) begin  // eight back-to-back apples
      case (i)
        0: add(0,0,1,0,0, 0,0,1,1,0);
        1: add(0,0,1,0,0, 1,0,1,1,0);
        2: add(0,0,1,0,0, 0,0,1,2,0);
        3: add(0,0,1,0,0, 0,0,1,3,0);
        4: add(0,0,1,0,0, 1,0,1,3,0);
        5: add(0,0,1,0,0, 0,0,1,4,0);
        6: add(0,0,1,0,0, 0,0,1,4,1);
        default: add(0,0,1,0,0, 1,0,1,4,1);
      endcase
    end
    for (int i = 0; i < 14; i++) begin  // drain: pulses every third cycle
      add(0,0,0,0,0, logic'(i % 3 == 2), 0, 1, 4 - (i + 1) / 3, 1);
    end
    add(0,0,1,0,0, 0,0,1,1,1);  // queue two, then pause
    add(0,0,1,0,0, 1,0,1,1,1);
    add(0,0,1,0,0, 0,0,1,2,1);
    add(0,1,0,0,0, 0,0,2,2,1);

    // Reset state and hold
    #3 rst = 1'b0;
    #1 chk_all("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    tick();

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].pa, vq[i].ap, vq[i].wa, vq[i].se);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vq[i].eg), int'(vq[i].eb), vq[i].es, vq[i].ep,
              int'(vq[i].eo));
    end

    // Paused: contents held, requests ignored
    goods = 0;
    bads = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, logic'(i % 2), 1'b0, logic'(i == 5));
      tick();
      goods += int'(goodCollButton);
      bads += int'(badCollButton);
      chk($sformatf("pause%0d.pending", i), int'(pending), 2);
    end
    chk("pause.goods", goods, 0);
    chk("pause.state", int'(game_state), 2);
    drive(0, 1, 0, 0, 0);
    tick();
    chk("resume.state", int'(game_state), 1);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      goods += int'(goodCollButton);
      bads += int'(badCollButton);
    end
    chk("resume.goods", goods, 2);
    chk("resume.bads", bads, 0);
    chk("resume.pending", int'(pending), 0);

    // Reset mid-queue while a pulse is high
    drive(0, 0, 1, 0, 0);
    tick();
    tick();
    chk("midq.good", int'(goodCollButton), 1);
    chk("midq.pending", int'(pending), 1);
    drive(1, 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("async_hold%0d", i), 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("held_start%0d.state", i), int'(game_state), 0);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    chk_all("restart", 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
